// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vga_fb_arbiter
// Description : Frame-buffer RAM port arbiter. Pixel fetches for the VGA
//               scan-out own one cycle in every 32-cycle horizontal block.
//               Game-logic writes use all other cycles. A CLEAR/SYNC/RUN
//               state machine zero-fills the buffer after reset or on
//               request, and then locks onto the top-left of the frame.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_fb_arbiter #(
    parameter int WPL         = 42,
    parameter int LINES       = 480,
    parameter int FB_AW       = 15,
    parameter int H_FIRST_BLK = 6,
    parameter int V_FIRST     = 12,
    parameter int V_LAST      = 491
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [0:10]      hcnt,
    input  logic [0:9]       vcnt,
    input  logic             clr_req,
    input  logic             wr_req,
    input  logic [FB_AW-1:0] wr_addr,
    input  logic [47:0]      wr_data,
    output logic             wr_ack,
    output logic             wr_err,
    output logic             ram_en,
    output logic             ram_we,
    output logic [FB_AW-1:0] ram_addr,
    output logic [47:0]      ram_wdata,
    input  logic [47:0]      ram_rdata,
    output logic [47:0]      pixels,
    output logic             vga_enable,
    output logic             vga_clear,
    output logic             frame_done
);

    localparam int               c_fb_words   = WPL * LINES;
    localparam logic [FB_AW-1:0] c_sweep_last = FB_AW'(c_fb_words - 1);
    localparam logic [4:0]       c_ph_fetch   = 5'd26;
    localparam logic [4:0]       c_ph_load    = 5'd28;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_SYNC  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t           r_state;
    logic [FB_AW-1:0] r_sweep_addr;
    logic             r_vga_enable;
    logic [47:0]      r_pixels;
    logic [47:0]      r_rdata;
    logic             r_rd_d1;
    logic             r_rd_d2;

    // hcnt is numbered MSB-first: [0:5] is the 32-cycle block, [6:10] the phase
    logic [5:0]       w_blk;
    logic [4:0]       w_phase;
    logic [9:0]       w_line_cnt;
    logic             w_slot;
    logic             w_h_ok;
    logic             w_v_ok;
    logic             w_fetch;
    logic [31:0]      w_group;
    logic [31:0]      w_line;
    logic [FB_AW-1:0] w_fetch_addr;
    logic             w_wr_go;
    logic             w_wr_in_range;
    logic             w_hv_zero;

    assign w_blk      = hcnt[0:5];
    assign w_phase    = hcnt[6:10];
    assign w_line_cnt = vcnt;
    assign w_hv_zero  = (hcnt == 11'd0) && (vcnt == 10'd0);

    // Every phase-26 cycle is reserved for the fetch, valid or not
    assign w_slot  = (w_phase == c_ph_fetch);
    assign w_h_ok  = (32'(w_blk) >= 32'(H_FIRST_BLK)) &&
                     (32'(w_blk) <  32'(H_FIRST_BLK + WPL));
    assign w_v_ok  = (32'(w_line_cnt) >= 32'(V_FIRST)) &&
                     (32'(w_line_cnt) <= 32'(V_LAST));
    assign w_fetch = (r_state == ST_RUN) && w_slot && w_h_ok && w_v_ok;

    // Address arithmetic is done at 32 bits; only in-range results are used
    assign w_group      = 32'(w_blk) - 32'(H_FIRST_BLK);
    assign w_line       = 32'(w_line_cnt) - 32'(V_FIRST);
    assign w_fetch_addr = FB_AW'(w_line * 32'(WPL) + w_group);

    // A clear request in the same cycle wins over a write so it is never acked
    assign w_wr_go       = (r_state == ST_RUN) && wr_req && !w_slot && !clr_req;
    assign w_wr_in_range = (32'(wr_addr) < 32'(c_fb_words));

    assign frame_done = (r_state == ST_RUN) && (hcnt == 11'd0) &&
                        (32'(w_line_cnt) == 32'(V_LAST + 1));
    assign vga_clear  = (r_state != ST_RUN);
    assign vga_enable = r_vga_enable;
    assign pixels     = r_pixels;

    // RAM port mux; the sweep is gated by rst so reset drives an idle port
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        wr_ack    = 1'b0;
        wr_err    = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                if (rst) begin
                    ram_en   = 1'b1;
                    ram_we   = 1'b1;
                    ram_addr = r_sweep_addr;
                end
            end
            ST_RUN: begin
                if (w_fetch) begin
                    ram_en   = 1'b1;
                    ram_addr = w_fetch_addr;
                end else if (w_wr_go) begin
                    wr_ack = 1'b1;
                    if (w_wr_in_range) begin
                        ram_en    = 1'b1;
                        ram_we    = 1'b1;
                        ram_addr  = wr_addr;
                        ram_wdata = wr_data;
                    end else begin
                        wr_err = 1'b1;
                    end
                end
            end
            default: begin
                ram_en = 1'b0;
            end
        endcase
    end

    // State machine, sweep counter and the fetch/pixel pipeline
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_CLEAR;
            r_sweep_addr <= '0;
            r_vga_enable <= 1'b0;
            r_pixels     <= '0;
            r_rdata      <= '0;
            r_rd_d1      <= 1'b0;
            r_rd_d2      <= 1'b0;
        end else begin
            r_vga_enable <= 1'b1;

            // Read data arrives the cycle after the fetch; park it until phase 28
            r_rd_d1 <= w_fetch;
            r_rd_d2 <= r_rd_d1;
            if (r_rd_d1) begin
                r_rdata <= ram_rdata;
            end
            if (w_phase == c_ph_load) begin
                r_pixels <= r_rd_d2 ? r_rdata : 48'd0;
            end

            case (r_state)
                ST_CLEAR: begin
                    if (r_sweep_addr == c_sweep_last) begin
                        r_state      <= ST_SYNC;
                        r_sweep_addr <= '0;
                    end else begin
                        r_sweep_addr <= r_sweep_addr + 1'b1;
                    end
                end
                ST_SYNC: begin
                    if (w_hv_zero) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (clr_req) begin
                        r_state      <= ST_CLEAR;
                        r_sweep_addr <= '0;
                    end
                end
                default: begin
                    r_state      <= ST_CLEAR;
                    r_sweep_addr <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_fb_arbiter
// Description : Directed bench for vga_fb_arbiter with a behavioural RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_fb_arbiter;

    localparam int FB_AW = 15;

    logic             clk = 1'b0;
    logic             rst;
    logic [0:10]      hcnt;
    logic [0:9]       vcnt;
    logic             clr_req;
    logic             wr_req;
    logic [FB_AW-1:0] wr_addr;
    logic [47:0]      wr_data;
    logic             wr_ack;
    logic             wr_err;
    logic             ram_en;
    logic             ram_we;
    logic [FB_AW-1:0] ram_addr;
    logic [47:0]      ram_wdata;
    logic [47:0]      ram_rdata;
    logic [47:0]      pixels;
    logic             vga_enable;
    logic             vga_clear;
    logic             frame_done;

    logic [47:0]      mem [0:32767];
    logic             bd_we;
    logic [FB_AW-1:0] bd_addr;
    logic [47:0]      bd_data;

    int n_pass  = 0;
    int n_total = 0;

    always #10 clk = ~clk;

    vga_fb_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .hcnt       (hcnt),
        .vcnt       (vcnt),
        .clr_req    (clr_req),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .wr_err     (wr_err),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .pixels     (pixels),
        .vga_enable (vga_enable),
        .vga_clear  (vga_clear),
        .frame_done (frame_done)
    );

    // Single-port RAM, read-first, one cycle read latency, plus a backdoor port
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
        if (bd_we) mem[bd_addr] <= bd_data;
    end

    typedef struct {
        int          h;
        int          v;
        logic        wr;
        int          wa;
        logic [47:0] wd;
        logic        en;
        logic        we;
        int          addr;
        logic [47:0] wdat;
        logic        ack;
        logic        err;
        logic        fd;
    } vec_t;

    vec_t vecs [18];

    localparam logic [47:0] D1   = 48'hA5A5_0000_1234;
    localparam logic [47:0] D2   = 48'h0F0F_F0F0_5555;
    localparam logic [47:0] D3   = 48'h1357_9BDF_2468;
    localparam logic [47:0] RAM0 = 48'h0123_4567_89AB;
    localparam logic [47:0] RAMC = 48'hBEEF_CAFE_0001;
    localparam logic [47:0] DC   = 48'h7777_8888_9999;
    localparam logic [47:0] MARK = 48'hDEAD_0000_BEEF;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [95:0] stat();
        return {41'd0, ram_en, ram_we, wr_ack, wr_err, frame_done,
                vga_enable, vga_clear, pixels};
    endfunction

    task automatic drive(input int h, input int v);
        hcnt = 11'(h);
        vcnt = 10'(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bd_write(input int a, input logic [47:0] d);
        bd_addr = 15'(a);
        bd_data = d;
        bd_we   = 1'b1;
        step();
        bd_we   = 1'b0;
    endtask

    // Follows one clear sweep; entered just after a rising edge
    task automatic sweep(input int limit, output int nw, output int ne);
        nw = 0;
        ne = 0;
        for (int c = 0; c < 21000; c++) begin
            case (c % 3)
                0:       drive(0, 492);
                1:       drive(218, 12);
                default: drive(5, 0);
            endcase
            clr_req = c[0];
            wr_req  = 1'b1;
            wr_addr = 15'd5;
            wr_data = '1;
            @(negedge clk);
            if (wr_ack || frame_done || !vga_clear) ne++;
            if (ram_en) begin
                if (!(ram_we && ram_addr == 15'(nw) && ram_wdata == 48'd0)) ne++;
                if (nw > 0 && !vga_enable) ne++;
                nw++;
                if (nw == limit) break;
            end else if (nw > 0) begin
                break;
            end else begin
                ne++;
            end
            step();
        end
    endtask

    // From SYNC into RUN via the hcnt=0/vcnt=0 point
    task automatic go_run();
        wr_req  = 1'b0;
        clr_req = 1'b1;
        drive(218, 12);
        @(negedge clk);
        chk("sync_hold", {94'd0, ram_en, vga_clear}, {94'd0, 2'b01});
        step();
        clr_req = 1'b0;
        drive(0, 0);
        @(negedge clk);
        chk("sync_exit_clear", {95'd0, vga_clear}, 96'd1);
        step();
        drive(1, 0);
        @(negedge clk);
        chk("run_clear_low", {95'd0, vga_clear}, 96'd0);
        step();
    endtask

    // Walks hcnt from two before a slot to its phase 30 and checks pixels
    task automatic pix_seq(input int v, input int h0, input logic [47:0] exp, input string nm);
        wr_req = 1'b0;
        for (int k = 0; k < 6; k++) begin
            drive(h0 + k, v);
            step();
        end
        drive(h0 + 6, v);
        @(negedge clk);
        chk(nm, {48'd0, pixels}, {48'd0, exp});
        step();
    endtask

    initial begin
        int nw;
        int ne;

        vecs[0]  = '{218, 12,  0, 0,     48'd0, 1, 0, 0,     48'd0, 0, 0, 0};
        vecs[1]  = '{250, 12,  0, 0,     48'd0, 1, 0, 1,     48'd0, 0, 0, 0};
        vecs[2]  = '{218, 13,  0, 0,     48'd0, 1, 0, 42,    48'd0, 0, 0, 0};
        vecs[3]  = '{186, 12,  0, 0,     48'd0, 0, 0, 0,     48'd0, 0, 0, 0};
        vecs[4]  = '{218, 11,  0, 0,     48'd0, 0, 0, 0,     48'd0, 0, 0, 0};
        vecs[5]  = '{1530, 491, 0, 0,    48'd0, 1, 0, 20159, 48'd0, 0, 0, 0};
        vecs[6]  = '{1562, 491, 0, 0,    48'd0, 0, 0, 0,     48'd0, 0, 0, 0};
        vecs[7]  = '{218, 492, 0, 0,     48'd0, 0, 0, 0,     48'd0, 0, 0, 0};
        vecs[8]  = '{219, 100, 1, 7,     D1,    1, 1, 7,     D1,    1, 0, 0};
        vecs[9]  = '{218, 100, 1, 7,     D1,    1, 0, 3696,  48'd0, 0, 0, 0};
        vecs[10] = '{220, 100, 1, 20159, D2,    1, 1, 20159, D2,    1, 0, 0};
        vecs[11] = '{220, 100, 1, 20160, D2,    0, 0, 0,     48'd0, 1, 1, 0};
        vecs[12] = '{220, 100, 1, 32767, D2,    0, 0, 0,     48'd0, 1, 1, 0};
        vecs[13] = '{0,   492, 0, 0,     48'd0, 0, 0, 0,     48'd0, 0, 0, 1};
        vecs[14] = '{1,   492, 0, 0,     48'd0, 0, 0, 0,     48'd0, 0, 0, 0};
        vecs[15] = '{0,   491, 0, 0,     48'd0, 0, 0, 0,     48'd0, 0, 0, 0};
        vecs[16] = '{219, 300, 0, 0,     48'd0, 0, 0, 0,     48'd0, 0, 0, 0};
        vecs[17] = '{154, 100, 1, 9,     D3,    0, 0, 0,     48'd0, 0, 0, 0};

        rst     = 1'b0;
        clr_req = 1'b0;
        wr_req  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        bd_we   = 1'b0;
        bd_addr = '0;
        bd_data = '0;
        drive(100, 100);

        bd_write(0,     MARK);
        bd_write(1,     MARK);
        bd_write(20159, MARK);
        bd_write(20160, MARK);
        @(negedge clk);
        chk("reset_state", stat(), {41'd0, 7'b0000001, 48'd0});

        step();
        rst = 1'b1;
        sweep(30000, nw, ne);
        chk("sweep1_len", 96'(nw), 96'd20160);
        chk("sweep1_seq", 96'(ne), 96'd0);
        chk("clr_mem0",     {48'd0, mem[0]},     96'd0);
        chk("clr_mem1",     {48'd0, mem[1]},     96'd0);
        chk("clr_mem_last", {48'd0, mem[20159]}, 96'd0);
        chk("clr_mem_past", {48'd0, mem[20160]}, {48'd0, MARK});
        step();
        go_run();

        foreach (vecs[i]) begin
            drive(vecs[i].h, vecs[i].v);
            wr_req  = vecs[i].wr;
            wr_addr = 15'(vecs[i].wa);
            wr_data = vecs[i].wd;
            @(negedge clk);
            chk($sformatf("vec%0d", i),
                {28'd0, ram_en, ram_we, ram_addr, ram_wdata, wr_ack, wr_err, frame_done},
                {28'd0, vecs[i].en, vecs[i].we, 15'(vecs[i].addr), vecs[i].wdat,
                 vecs[i].ack, vecs[i].err, vecs[i].fd});
            step();
        end

        wr_req = 1'b0;
        drive(5, 0);
        bd_write(0, RAM0);
        pix_seq(12, 216, RAM0,  "pix_fetch");
        pix_seq(11, 216, 48'd0, "pix_v_out");
        pix_seq(12, 216, RAM0,  "pix_refetch");
        pix_seq(12, 184, 48'd0, "pix_h_out");

        // Write colliding with a fetch slot stalls exactly one cycle
        drive(5, 0);
        bd_write(3696, RAMC);
        drive(217, 100);
        step();
        drive(218, 100);
        wr_req  = 1'b1;
        wr_addr = 15'd300;
        wr_data = DC;
        @(negedge clk);
        chk("coll_218", {78'd0, ram_en, ram_we, ram_addr, wr_ack},
                        {78'd0, 1'b1, 1'b0, 15'd3696, 1'b0});
        step();
        drive(219, 100);
        @(negedge clk);
        chk("coll_219", {30'd0, ram_en, ram_we, ram_addr, ram_wdata, wr_ack},
                        {30'd0, 1'b1, 1'b1, 15'd300, DC, 1'b1});
        step();
        wr_req = 1'b0;
        drive(220, 100);
        step();
        drive(221, 100);
        step();
        drive(222, 100);
        @(negedge clk);
        chk("coll_pixels", {48'd0, pixels}, {48'd0, RAMC});
        chk("coll_mem",    {48'd0, mem[300]}, {48'd0, DC});
        step();

        // Clear request with a write pending: no ack, sweep from 0
        drive(300, 100);
        wr_req  = 1'b1;
        wr_addr = 15'd5;
        wr_data = '1;
        clr_req = 1'b1;
        @(negedge clk);
        chk("clr_no_ack", {94'd0, wr_ack, ram_we}, 96'd0);
        step();
        clr_req = 1'b0;
        sweep(100, nw, ne);
        chk("sweep2_len", 96'(nw), 96'd100);
        chk("sweep2_seq", 96'(ne), 96'd0);

        // Reset in the middle of a sweep
        #2;
        rst = 1'b0;
        #1;
        chk("reset_mid", stat(), {41'd0, 7'b0000001, 48'd0});
        step();
        rst = 1'b1;
        sweep(30000, nw, ne);
        chk("sweep3_len", 96'(nw), 96'd20160);
        chk("sweep3_seq", 96'(ne), 96'd0);
        step();
        go_run();

        drive(0, 492);
        wr_req = 1'b0;
        @(negedge clk);
        chk("frame_done_run", {95'd0, frame_done}, 96'd1);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
